// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Optional saturation on signed overflow when CSEL_SATURATE_EN is defined (adds the sat port).
module pipelined_csel_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CSEL_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NBLK = WIDTH / BLK;
  localparam int BPS  = NBLK / STAGES;
  localparam int SEGW = BPS * BLK;

  if ((BLK < 1) || (WIDTH % BLK != 0)) begin : g_chk_blk
    $error("WIDTH must be a positive multiple of BLK");
  end
  if ((STAGES < 1) || (STAGES > NBLK) || (NBLK % STAGES != 0)) begin : g_chk_stages
    $error("STAGES must divide WIDTH/BLK and lie in 1..WIDTH/BLK");
  end

  // One segment of carry-select blocks: both carry hypotheses per block, then select.
  function automatic logic [SEGW:0] csel_seg(input logic [SEGW-1:0] x,
                                             input logic [SEGW-1:0] y,
                                             input logic            c);
    logic [SEGW-1:0] s;
    logic            carry;
    logic [BLK:0]    r0;
    logic [BLK:0]    r1;
    s     = '0;
    carry = c;
    for (int i = 0; i < BPS; i++) begin
      r0 = {1'b0, x[i*BLK +: BLK]} + {1'b0, y[i*BLK +: BLK]};
      r1 = {1'b0, x[i*BLK +: BLK]} + {1'b0, y[i*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
      {carry, s[i*BLK +: BLK]} = carry ? r1 : r0;
    end
    return {carry, s};
  endfunction

  logic             advance;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // All stages move together; a stalled output freezes the whole pipe.
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

  assign b_eff = b ^ {WIDTH{sub}};
  assign c0    = cin ^ sub;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stg
    localparam int LO = gi * SEGW;
    localparam int HI = LO + SEGW;

    logic [WIDTH-LO-1:0] op_a;
    logic [WIDTH-LO-1:0] op_b;
    logic                c_in;
    logic                v_in;
    logic [SEGW:0]       seg_r;
    logic [HI-1:0]       acc_sum;
`ifdef CSEL_SATURATE_EN
    logic                s_in;
`endif

    assign seg_r = csel_seg(op_a[SEGW-1:0], op_b[SEGW-1:0], c_in);

    if (gi == 0) begin : g_src
      assign op_a    = a;
      assign op_b    = b_eff;
      assign c_in    = c0;
      assign v_in    = in_valid;
      assign acc_sum = seg_r[SEGW-1:0];
`ifdef CSEL_SATURATE_EN
      assign s_in    = sat;
`endif
    end else begin : g_src
      assign op_a    = g_stg[gi-1].g_reg.a_q;
      assign op_b    = g_stg[gi-1].g_reg.b_q;
      assign c_in    = g_stg[gi-1].g_reg.c_q;
      assign v_in    = g_stg[gi-1].g_reg.v_q;
      assign acc_sum = {seg_r[SEGW-1:0], g_stg[gi-1].g_reg.s_q};
`ifdef CSEL_SATURATE_EN
      assign s_in    = g_stg[gi-1].g_reg.sat_q;
`endif
    end

    if (gi < STAGES - 1) begin : g_reg
      // Resolved low sum bits plus the still-unresolved upper operand bits.
      logic                v_q;
      logic                c_q;
      logic [HI-1:0]       s_q;
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;
`ifdef CSEL_SATURATE_EN
      logic                sat_q;
`endif
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= v_in;
          if (v_in) begin
            c_q <= seg_r[SEGW];
            s_q <= acc_sum;
            a_q <= op_a[WIDTH-LO-1:SEGW];
            b_q <= op_b[WIDTH-LO-1:SEGW];
`ifdef CSEL_SATURATE_EN
            sat_q <= s_in;
`endif
          end
        end
      end
    end else begin : g_out
      logic             ovf;
      logic [WIDTH-1:0] res;

      // The last segment holds the operand MSBs, so overflow is decided here.
      assign ovf = (op_a[SEGW-1] == op_b[SEGW-1]) && (acc_sum[WIDTH-1] != op_a[SEGW-1]);
`ifdef CSEL_SATURATE_EN
      assign res = (s_in && ovf) ? (op_a[SEGW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}})
                                 : acc_sum;
`else
      assign res = acc_sum;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
        end else if (advance) begin
          out_valid_q <= v_in;
          if (v_in) begin
            sum_q  <= res;
            cout_q <= seg_r[SEGW];
            ovf_q  <= ovf;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Scoreboard bench for pipelined_csel_addsub: directed corner cases, stall/reset scenarios, random traffic.
// Saturation cases are exercised only when CSEL_SATURATE_EN is defined.
module tb_pipelined_csel_addsub;
  localparam int W   = 32;
  localparam int STG = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  always #5 clk = ~clk;

  pipelined_csel_addsub #(.WIDTH(W), .BLK(4), .STAGES(STG)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
`ifdef CSEL_SATURATE_EN
    .sat      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_edge;
    int           stalls_at;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           edge_cnt = 0;
  int           stalls = 0;
  int           ro_mode = 0;
  int           txn = 0;
  logic         hold_v = 1'b0;
  logic [W+1:0] held;

  // Reference: integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub, input logic msat);
    exp_t         r;
    logic [W-1:0] be;
    logic [W:0]   full;
    longint       s;
    be   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, mcin ^ msub};
    s    = longint'($signed(ma)) + longint'($signed(be)) + longint'(mcin ^ msub);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    if (msat && r.ovf) r.sum = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    r.acc_edge  = 0;
    r.stalls_at = 0;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) begin
    if (ro_mode == 1) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: samples mid-cycle, i.e. the handshakes the next rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (hold_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'({sum, cout, overflow}), 64'(held));
      end
      if (in_valid && in_ready) begin
        mon_e = model(a, b, cin, sub, sat);
        mon_e.acc_edge  = edge_cnt + 1;
        mon_e.stalls_at = stalls;
        sb.push_back(mon_e);
      end
      if (out_valid && !out_ready) begin
        hold_v = 1'b1;
        held   = {sum, cout, overflow};
        stalls++;
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got sum=%h with nothing outstanding, required no output", sum);
        end else begin
          mon_e = sb.pop_front();
          check("sum", 64'(sum), 64'(mon_e.sum));
          check("cout", 64'(cout), 64'(mon_e.cout));
          check("overflow", 64'(overflow), 64'(mon_e.ovf));
          check("latency", 64'(edge_cnt + 1 - mon_e.acc_edge), 64'(STG + stalls - mon_e.stalls_at));
          $display("txn %0d: sum=%h cout=%b ovf=%b (model sum=%h cout=%b ovf=%b)",
                   txn, sum, cout, overflow, mon_e.sum, mon_e.cout, mon_e.ovf);
          txn++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the operation.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic ts, input logic tsat);
    bit ok;
    a = ta; b = tb; cin = tc; sub = ts; sat = tsat;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required acceptance");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sat = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    send(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
`ifdef CSEL_SATURATE_EN
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
`endif
    drain();

    // Back-to-back stream with the consumer stalling for three cycles.
    fork
      for (int i = 0; i < 6; i++) send(W'(i), 32'h0000_0100, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_sum", 64'(sum), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random gaps and random backpressure.
    ro_mode = 1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
`ifdef CSEL_SATURATE_EN
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
`endif
    end
    ro_mode = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_csel_addsub.md
Name: pipelined_csel_addsub

Overview:
Parametrised, pipelined carry-select adder/subtractor with a valid/ready stream interface. It is the next generation of the team's 32-bit combinational carry-select adder: width, block size and pipeline depth are configurable, subtraction with borrow-in is added, and signed overflow is flagged without altering the sum. It sits in the ALU datapath between operand issue and writeback and absorbs writeback backpressure.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of BLK.
BLK, 4, carry-select block width in bits.
STAGES, 2, pipeline register stages; (WIDTH/BLK) must be divisible by STAGES; 1 <= STAGES <= WIDTH/BLK. A violation is an elaboration-time error.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input operands valid.
in_ready  output  1  block accepts input this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result.
cout  output  1  raw carry out of the MSB.
overflow  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Arithmetic: b_eff = b XOR {WIDTH{sub}}, c0 = cin XOR sub; result = a + b_eff + c0, modulo 2^WIDTH.
  - sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
  - cout = carry out of bit WIDTH-1. For subtraction, cout=1 means no borrow.
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Structure: WIDTH/BLK blocks. Each block computes sum/carry for carry-in 0 and 1 in parallel, then a mux selects on the incoming block carry.
  - Blocks are grouped into STAGES equal segments, LSB segment first.
  - Stage k resolves segment k using the registered inter-segment carry from stage k-1.
  - Unresolved upper operand bits and completed lower sum bits are carried forward in the pipeline registers.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready at edge N) to out_valid at edge N+STAGES, if out_ready stays high.
- Throughput: one result per cycle.
- Handshake: global advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, all stage registers and outputs hold.
  - Bubbles are not collapsed.
  - sum, cout and overflow are stable while out_valid && !out_ready.
  - Input is accepted only when in_valid && in_ready. in_valid may drop at any time.
- Ordering: results leave in acceptance order; no loss or duplication.
- Reset: all stage valid bits, out_valid, sum, cout and overflow clear to 0; in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; none emerge afterwards.
  - rst has priority over any handshake in the same cycle.
- Edge cases:
  - STAGES=1 degenerates to a fully combinational carry-select path plus an output register.
  - a=b=0, cin=1, sub=0 gives sum=1.
  - Simultaneous output pop and input push in a full pipeline is allowed; occupancy is unchanged.

Optional Feature:
Macro CSEL_SATURATE_EN.
- Defined: adds input port sat (1 bit), registered alongside the operands.
  - When sat=1 and overflow=1, sum is clamped to 0x7FF..F if a[MSB]=0, or 0x800..0 if a[MSB]=1.
  - overflow still reports 1; cout is unchanged.
  - When sat=0, output is identical to the undefined case.
- Undefined: no sat port; sum always wraps modulo 2^WIDTH.

Test Plan:
(WIDTH=32, BLK=4, STAGES=2, out_ready=1 unless stated)
1. a=0x0000000F, b=0x00000001, cin=0, sub=0 accepted at edge N -> at N+2: out_valid=1, sum=0x00000010, cout=0, overflow=0.
2. a=0x7FFFFFFF, b=0x00000001, add -> sum=0x80000000, cout=0, overflow=1. With CSEL_SATURATE_EN and sat=1 -> sum=0x7FFFFFFF, overflow=1.
3. a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, overflow=0. Same operands with cin=1 -> sum=0xFFFFFFFD.
4. a=0x80000000, b=0x80000000, add -> sum=0x00000000, cout=1, overflow=1. With saturation (sat=1) -> sum=0x80000000.
5. Stream 6 back-to-back adds (a=i, b=0x100, i=0..5) with out_ready low on cycles 3-5 -> in_ready low while stalled, outputs held stable, results 0x100..0x105 in order, no loss or duplication.
6. Accept 2 operations, assert rst for 1 cycle before either emerges -> out_valid=0 the next cycle, no stale results later, in_ready=1 after reset.
